ocp_slave_mem: RTL

//  OCP 3.0 single-thread slave sitting directly downstream of ocp_master_fsm.

---
 rtl/ocp_slave_mem_pkg.sv | 37 +++
 rtl/ocp_slave_mem_regfile.sv | 31 +++
 rtl/ocp_slave_mem.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/ocp_slave_mem_pkg.sv
// Shared OCP command/response codes and the counter type used by the slave memory.
package ocp_slave_mem_pkg;

    typedef enum logic [2:0] {
        MCMD_IDLE = 3'd0,
        MCMD_WR   = 3'd1,
        MCMD_RD   = 3'd2,
        MCMD_RDEX = 3'd3,
        MCMD_RDL  = 3'd4,
        MCMD_WRNP = 3'd5,
        MCMD_WRC  = 3'd6,
        MCMD_BCST = 3'd7
    } mcmd_e;

    typedef enum logic [1:0] {
        SRESP_NULL = 2'd0,
        SRESP_DVA  = 2'd1,
        SRESP_FAIL = 2'd2,
        SRESP_ERR  = 2'd3
    } sresp_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCEPT = 2'd1,
        ST_RDLY   = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    localparam int CNT_W = 4;
    typedef logic [CNT_W-1:0] cnt_t;

    // Wait counters stick at all-ones rather than wrapping.
    function automatic cnt_t cnt_sat_inc(input cnt_t c);
        return (c == '1) ? c : cnt_t'(c + 1'b1);
    endfunction

endpackage

// File: rtl/ocp_slave_mem_regfile.sv
// Local byte store: one synchronous write port, one asynchronous read port,
// cleared synchronously while reset is asserted.
module ocp_slave_mem_regfile #(
    parameter int DEPTH     = 256,
    parameter int DATA_WDTH = 8,
    parameter int IDX_W     = $clog2(DEPTH)
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 wr_en_i,
    input  logic [IDX_W-1:0]     wr_idx_i,
    input  logic [DATA_WDTH-1:0] wr_data_i,
    input  logic [IDX_W-1:0]     rd_idx_i,
    output logic [DATA_WDTH-1:0] rd_data_o
);

    logic [DATA_WDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            mem_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/ocp_slave_mem.sv
// OCP single-thread slave with a local byte store; one outstanding transaction.
//   state  | meaning
//   IDLE   | no request accepted; counting how long MCmd has been held
//   ACCEPT | SCmdAccept high; request is consumed on the next enabled edge
//   RDLY   | read/error accepted, waiting RESP_WAIT cycles before responding
//   RESP   | SResp driven until the master accepts (or for one cycle)
module ocp_slave_mem
    import ocp_slave_mem_pkg::*;
#(
    parameter int ADDR_WDTH   = 64,
    parameter int DATA_WDTH   = 8,
    parameter int DEPTH       = 256,
    parameter int ACCEPT_WAIT = 0,
    parameter int RESP_WAIT   = 0,
    parameter int RESP_ACC_EN = 1
) (
    input  logic                 Clk,
    input  logic                 MReset_n,
    input  logic                 EnableClk,
    input  logic [2:0]           MCmd,
    input  logic [ADDR_WDTH-1:0] MAddr,
    input  logic [DATA_WDTH-1:0] MData,
    input  logic                 MRespAccept,
    output logic                 SCmdAccept,
    output logic [1:0]           SResp,
    output logic [DATA_WDTH-1:0] SData
);

    localparam int   IDX_W     = $clog2(DEPTH);
    localparam cnt_t ACC_LAST  = cnt_t'(ACCEPT_WAIT);
    localparam cnt_t RDLY_LAST = cnt_t'((RESP_WAIT > 0) ? RESP_WAIT - 1 : 0);

    state_e               state_q, state_d;
    cnt_t                 wait_cnt_q, wait_cnt_d;
    cnt_t                 resp_cnt_q, resp_cnt_d;
    logic [IDX_W-1:0]     addr_q, addr_d;
    logic                 err_q, err_d;
    logic                 scmd_acc_q, scmd_acc_d;
    sresp_e               sresp_q, sresp_d;
    logic [DATA_WDTH-1:0] sdata_q, sdata_d;

    logic [IDX_W-1:0]     req_idx;
    logic                 req_in_range;
    logic                 wr_en;
    logic [IDX_W-1:0]     rd_idx;
    logic [DATA_WDTH-1:0] rd_data;

    assign req_idx      = MAddr[IDX_W-1:0];
    assign req_in_range = (MAddr[ADDR_WDTH-1:IDX_W] == '0);

    // A direct ACCEPT->RESP hop has not latched the address yet, so read via MAddr.
    assign rd_idx = (state_q == ST_ACCEPT) ? req_idx : addr_q;

    ocp_slave_mem_regfile #(
        .DEPTH     (DEPTH),
        .DATA_WDTH (DATA_WDTH),
        .IDX_W     (IDX_W)
    ) u_regfile (
        .clk_i     (Clk),
        .rst_n_i   (MReset_n),
        .wr_en_i   (wr_en & EnableClk),
        .wr_idx_i  (req_idx),
        .wr_data_i (MData),
        .rd_idx_i  (rd_idx),
        .rd_data_o (rd_data)
    );

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        resp_cnt_d = resp_cnt_q;
        addr_d     = addr_q;
        err_d      = err_q;
        wr_en      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (MCmd != MCMD_IDLE) begin
                    if (wait_cnt_q == ACC_LAST) begin
                        state_d    = ST_ACCEPT;
                        wait_cnt_d = '0;
                    end else begin
                        wait_cnt_d = cnt_sat_inc(wait_cnt_q);
                    end
                end else begin
                    wait_cnt_d = '0;
                end
            end
            ST_ACCEPT: begin
                case (MCmd)
                    MCMD_IDLE: state_d = ST_IDLE;
                    MCMD_WR: begin
                        wr_en   = req_in_range;
                        state_d = ST_IDLE;
                    end
                    default: begin
                        addr_d     = req_idx;
                        err_d      = !((MCmd == MCMD_RD) && req_in_range);
                        resp_cnt_d = '0;
                        state_d    = (RESP_WAIT == 0) ? ST_RESP : ST_RDLY;
                    end
                endcase
            end
            ST_RDLY: begin
                if (resp_cnt_q == RDLY_LAST) begin
                    state_d    = ST_RESP;
                    resp_cnt_d = '0;
                end else begin
                    resp_cnt_d = cnt_sat_inc(resp_cnt_q);
                end
            end
            ST_RESP: begin
                if ((RESP_ACC_EN == 0) || MRespAccept) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_comb begin
        scmd_acc_d = (state_d == ST_ACCEPT);
        sresp_d    = SRESP_NULL;
        sdata_d    = '0;
        if (state_d == ST_RESP) begin
            if (err_d) begin
                sresp_d = SRESP_ERR;
            end else begin
                sresp_d = SRESP_DVA;
                sdata_d = rd_data;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!MReset_n) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
            resp_cnt_q <= '0;
            addr_q     <= '0;
            err_q      <= 1'b0;
            scmd_acc_q <= 1'b0;
            sresp_q    <= SRESP_NULL;
            sdata_q    <= '0;
        end else if (EnableClk) begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            resp_cnt_q <= resp_cnt_d;
            addr_q     <= addr_d;
            err_q      <= err_d;
            scmd_acc_q <= scmd_acc_d;
            sresp_q    <= sresp_d;
            sdata_q    <= sdata_d;
        end
    end

    assign SCmdAccept = scmd_acc_q;
    assign SResp      = sresp_q;
    assign SData      = sdata_q;

endmodule
